// File: rtl/bloom_builder.sv
// Bloom filter builder: sets four hashed bits per 25-bit word in a 64x64 filter.
// Define BLOOM_DUP_CHECK_EN to flag words whose four bits were all already set.
module bloom_builder (
  input  logic        clk,
  input  logic        rst,
  input  logic [24:0] in_word,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        clr,
  output logic        done,
  output logic        busy,
  output logic [10:0] word_count,
  input  logic [5:0]  rd_addr,
  output logic [63:0] rd_data,
  output logic        dup
);

  localparam int HASH_K = 4;
  localparam int ROWS   = 64;
  localparam int KW     = $clog2(HASH_K);

  localparam logic [1:0] S_CLEAR  = 2'd0;
  localparam logic [1:0] S_IDLE   = 2'd1;
  localparam logic [1:0] S_INSERT = 2'd2;

  // Coefficient rows packed with letter 0 in the low 12 bits.
  function automatic logic [11:0] hash_f(input logic [24:0] w, input logic [KW-1:0] k);
    logic [59:0] p;
    logic [11:0] acc;
    case (k)
      2'd0:    p = 60'hC0FDD0E6C6B31A5;
      2'd1:    p = 60'h9AE5CE874F694FC;
      2'd2:    p = 60'h28F60AC0AC8436E;
      default: p = 60'hCFB724DFEC61663;
    endcase
    acc = 12'd0;
    for (int j = 0; j < 5; j++) begin
      acc = acc + p[12*j +: 12] * {7'd0, w[5*j +: 5]};
    end
    return acc;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [5:0]    row_q, row_d;
  logic [KW-1:0] k_q, k_d;
  logic [24:0]   word_q, word_d;
  logic          done_q, done_d;
  logic [10:0]   wc_q, wc_d;
  logic [63:0]   rd_q;
  logic [63:0]   mem_q [ROWS];

  logic [11:0]   hash;
  logic [5:0]    bit_idx;

  assign hash    = hash_f(word_q, k_q);
  assign bit_idx = ~hash[5:0];

`ifdef BLOOM_DUP_CHECK_EN
  logic dupacc_q, dupacc_d;
  logic dup_q, dup_d;
  logic prior_bit;
  assign prior_bit = mem_q[hash[11:6]][bit_idx];
  assign dup       = dup_q;
`else
  assign dup = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    k_d     = k_q;
    word_d  = word_q;
    done_d  = 1'b0;
    wc_d    = wc_q;
`ifdef BLOOM_DUP_CHECK_EN
    dupacc_d = dupacc_q;
    dup_d    = 1'b0;
`endif
    case (state_q)
      S_CLEAR: begin
        row_d = row_q + 6'd1;
        if (row_q == 6'd63) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (clr) begin
          state_d = S_CLEAR;
          row_d   = 6'd0;
          wc_d    = 11'd0;
        end else if (in_valid) begin
          state_d = S_INSERT;
          word_d  = in_word;
          k_d     = '0;
`ifdef BLOOM_DUP_CHECK_EN
          dupacc_d = 1'b1;
`endif
        end
      end
      S_INSERT: begin
        k_d = k_q + KW'(1);
`ifdef BLOOM_DUP_CHECK_EN
        dupacc_d = dupacc_q & prior_bit;
`endif
        if (k_q == KW'(HASH_K - 1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
`ifdef BLOOM_DUP_CHECK_EN
          dup_d = dupacc_q & prior_bit;
          if (!(dupacc_q & prior_bit) && wc_q != 11'h7FF) wc_d = wc_q + 11'd1;
`else
          if (wc_q != 11'h7FF) wc_d = wc_q + 11'd1;
`endif
        end
      end
      default: begin
        state_d = S_CLEAR;
        row_d   = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_CLEAR;
      row_q   <= 6'd0;
      k_q     <= '0;
      done_q  <= 1'b0;
      wc_q    <= 11'd0;
      rd_q    <= 64'd0;
`ifdef BLOOM_DUP_CHECK_EN
      dupacc_q <= 1'b0;
      dup_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      k_q     <= k_d;
      done_q  <= done_d;
      wc_q    <= wc_d;
      rd_q    <= mem_q[rd_addr];
`ifdef BLOOM_DUP_CHECK_EN
      dupacc_q <= dupacc_d;
      dup_q    <= dup_d;
`endif
    end
  end

  // Filter storage and the latched word carry no reset; CLEAR initialises the rows.
  always_ff @(posedge clk) begin
    word_q <= word_d;
    if (state_q == S_CLEAR) mem_q[row_q] <= 64'd0;
    else if (state_q == S_INSERT) mem_q[hash[11:6]][bit_idx] <= 1'b1;
  end

  assign in_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign word_count = wc_q;
  assign rd_data    = rd_q;

endmodule

// File: tb/tb_bloom_builder.sv
// Directed self-checking bench for bloom_builder (default build; BLOOM_DUP_CHECK_EN adjusts dup expectations).
module tb_bloom_builder;

  logic        clk;
  logic        rst;
  logic [24:0] in_word;
  logic        in_valid;
  logic        in_ready;
  logic        clr;
  logic        done;
  logic        busy;
  logic [10:0] word_count;
  logic [5:0]  rd_addr;
  logic [63:0] rd_data;
  logic        dup;

  int total;
  int bad;

  bloom_builder dut (
    .clk        (clk),
    .rst        (rst),
    .in_word    (in_word),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .clr        (clr),
    .done       (done),
    .busy       (busy),
    .word_count (word_count),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .dup        (dup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic read_row(input int r);
    rd_addr = 6'(r);
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    for (int r = 0; r < 64; r++) begin
      read_row(r);
      check(tag, rd_data, 64'd0);
    end
  endtask

  // Accept one word, then walk the four insert cycles and check the done cycle.
  task automatic insert_word(input logic [24:0] w, input logic [10:0] exp_wc, input logic exp_dup);
    in_word  = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("accept_ready_low", {63'd0, in_ready}, 64'd0);
    check("insert_busy", {63'd0, busy}, 64'd1);
    tick(); tick(); tick();
    check("done_early", {63'd0, done}, 64'd0);
    tick();
    check("done_pulse", {63'd0, done}, 64'd1);
    check("done_ready", {63'd0, in_ready}, 64'd1);
    check("done_wc", {53'd0, word_count}, {53'd0, exp_wc});
    check("done_dup", {63'd0, dup}, {63'd0, exp_dup});
    tick();
    check("done_one_cycle", {63'd0, done}, 64'd0);
  endtask

  logic [63:0] exp_row;
  logic [24:0] b2b_words [3];
  logic        saw_done;
  logic [10:0] wc_base;

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    in_word  = 25'd0;
    in_valid = 1'b0;
    clr      = 1'b0;
    rd_addr  = 6'd0;
    b2b_words[0] = 25'h0000020;
    b2b_words[1] = 25'h0000400;
    b2b_words[2] = 25'h0100000;

    // Reset state
    tick(); tick();
    check("rst_ready", {63'd0, in_ready}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd1);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_wc", {53'd0, word_count}, 64'd0);
    check("rst_dup", {63'd0, dup}, 64'd0);
    check("rst_rd", rd_data, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 63; i++) tick();
    check("clear_63_ready", {63'd0, in_ready}, 64'd0);
    tick();
    check("clear_64_ready", {63'd0, in_ready}, 64'd1);
    check("idle_busy", {63'd0, busy}, 64'd0);
    check_all_zero("rst_rows_zero");

    // Single insert of letter0 = 1
    insert_word(25'h0000001, 11'd1, 1'b0);
    for (int r = 0; r < 64; r++) begin
      case (r)
        6:       exp_row = 64'h0000_0000_0400_0000;
        13:      exp_row = 64'd1 << 17;
        19:      exp_row = 64'd1 << 3;
        25:      exp_row = 64'd1 << 28;
        default: exp_row = 64'd0;
      endcase
      read_row(r);
      check("single_row", rd_data, exp_row);
    end

    // Same word again: duplicate behaviour depends on build
`ifdef BLOOM_DUP_CHECK_EN
    insert_word(25'h0000001, 11'd1, 1'b1);
    wc_base = 11'd1;
`else
    insert_word(25'h0000001, 11'd2, 1'b0);
    wc_base = 11'd2;
`endif

    // Back-to-back with in_valid held high
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_word = b2b_words[i];
      tick();
      check("b2b_accept", {63'd0, in_ready}, 64'd0);
      if (i == 2) in_valid = 1'b0;
      tick(); tick(); tick();
      check("b2b_no_done", {63'd0, done}, 64'd0);
      tick();
      check("b2b_done", {63'd0, done}, 64'd1);
    end
    check("b2b_wc", {53'd0, word_count}, {53'd0, wc_base + 11'd3});
    read_row(26);
    check("b2b_l1_h0", {63'd0, rd_data[12]}, 64'd1);
    read_row(61);
    check("b2b_l1_h1", {63'd0, rd_data[22]}, 64'd1);
    read_row(48);
    check("b2b_l4_h0", {63'd0, rd_data[48]}, 64'd1);

    // clr beats in_valid
    in_word  = 25'h0000001;
    in_valid = 1'b1;
    clr      = 1'b1;
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    check("clr_ready", {63'd0, in_ready}, 64'd0);
    check("clr_busy", {63'd0, busy}, 64'd1);
    check("clr_wc", {53'd0, word_count}, 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 63; i++) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    check("clr_63_ready", {63'd0, in_ready}, 64'd0);
    tick();
    check("clr_64_ready", {63'd0, in_ready}, 64'd1);
    check("clr_no_done", {63'd0, saw_done}, 64'd0);
    check("clr_wc_after", {53'd0, word_count}, 64'd0);
    check_all_zero("clr_rows_zero");

    // Saturation: more than 2047 inserts
    in_valid = 1'b1;
    for (int i = 0; i < 2052 * 5; i++) begin
      in_word = 25'(i * 7919 + 3);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
`ifdef BLOOM_DUP_CHECK_EN
    check("sat_nonzero", {63'd0, (word_count == 11'd0)}, 64'd0);
`else
    check("sat_wc", {53'd0, word_count}, 64'd2047);
`endif

    // Reset asserted just before E2 of an insert
    in_word  = 25'h0000001;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_ready", {63'd0, in_ready}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd1);
    check("midrst_wc", {53'd0, word_count}, 64'd0);
    tick();
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    check("midrst_no_done", {63'd0, saw_done}, 64'd0);
    check("midrst_ready_after", {63'd0, in_ready}, 64'd1);
    check_all_zero("midrst_rows_zero");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
